kernel_pr_start_consumer: RTL and testbench



---
 rtl/kernel_pr_ctrl_pkg.sv | 15 +
 rtl/kernel_pr_start_consumer.sv | 126 ++++++++++++
 tb/tb_kernel_pr_start_consumer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_pr_ctrl_pkg.sv
// Shared definitions for the kernel_pr start-token controllers.
// Holds the controller state encoding, the default bound on jobs in flight,
// and the default width of the completed-job counter.
package kernel_pr_ctrl_pkg;

    // IDLE: no start request outstanding. ISSUE: ap_start is being held.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam int DEFAULT_MAX_INFLIGHT = 4;
    localparam int DONE_CNT_WIDTH       = 32;

endpackage : kernel_pr_ctrl_pkg

// File: rtl/kernel_pr_start_consumer.sv
// Read-side controller for a 1-bit HLS dataflow start-token FIFO.
// Each popped token becomes one ap_ctrl_hs start handshake to the downstream
// process. Jobs in flight are bounded, completions are counted, a drain
// request stops new starts, and a done with nothing in flight is flagged.
//
// Ports:
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   start_empty_n FIFO holds a token
//   start_read    pop strobe to the FIFO (combinational, = ap_start & ap_ready)
//   ap_start      registered start request to the downstream process
//   ap_ready      downstream accepted the start
//   ap_done       downstream finished one job (1-cycle pulse)
//   drain_req     level; while high no new starts are issued
//   drain_done    registered: drain requested, idle and nothing in flight
//   inflight      jobs started and not yet done
//   done_count    accepted ap_done pulses, wraps
//   err_done      sticky flag: ap_done seen with nothing in flight
module kernel_pr_start_consumer
    import kernel_pr_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT,
    parameter int INFL_WIDTH   = 4,
    parameter int CNT_WIDTH    = DONE_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_empty_n,
    output logic                  start_read,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic [INFL_WIDTH-1:0] inflight,
    output logic [CNT_WIDTH-1:0]  done_count,
    output logic                  err_done
);

    localparam logic [INFL_WIDTH-1:0] INFL_MAX = INFL_WIDTH'(MAX_INFLIGHT);
    localparam logic [INFL_WIDTH-1:0] INFL_ONE = INFL_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    state_e                state_q, state_d;
    logic                  ap_start_q, ap_start_d;
    logic [INFL_WIDTH-1:0] inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  done_count_q, done_count_d;
    logic                  err_done_q, err_done_d;
    logic                  drain_done_q, drain_done_d;

    logic                  accept;
    logic                  done_ok;
    logic                  done_bad;

    // Handshake events for this cycle. ap_start_q mirrors the ISSUE state, so
    // the pop strobe only fires while a token was seen and not yet read.
    always_comb begin
        accept   = ap_start_q & ap_ready;
        done_ok  = ap_done & (inflight_q != '0);
        done_bad = ap_done & (inflight_q == '0);
    end

    // Next-state logic. ISSUE is never abandoned: only ap_ready leaves it,
    // so a late drain request cannot strand a half-issued start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_empty_n && !drain_req && (inflight_q < INFL_MAX)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ap_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ap_start_d = (state_d == ISSUE);
    end

    // Inflight up/down counter, completion counter and status flags.
    // An accept and a valid done in the same cycle cancel on inflight.
    always_comb begin
        inflight_d   = inflight_q;
        done_count_d = done_count_q;
        if (accept && !done_ok) begin
            inflight_d = inflight_q + INFL_ONE;
        end else if (!accept && done_ok) begin
            inflight_d = inflight_q - INFL_ONE;
        end
        if (done_ok) begin
            done_count_d = done_count_q + CNT_ONE;
        end
        err_done_d   = err_done_q | done_bad;
        drain_done_d = drain_req & (state_q == IDLE) & (inflight_q == '0);
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ap_start_q   <= 1'b0;
            inflight_q   <= '0;
            done_count_q <= '0;
            err_done_q   <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ap_start_q   <= ap_start_d;
            inflight_q   <= inflight_d;
            done_count_q <= done_count_d;
            err_done_q   <= err_done_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign start_read = accept;
    assign ap_start   = ap_start_q;
    assign inflight   = inflight_q;
    assign done_count = done_count_q;
    assign err_done   = err_done_q;
    assign drain_done = drain_done_q;

endmodule : kernel_pr_start_consumer

// File: tb/tb_kernel_pr_start_consumer.sv
// Testbench for kernel_pr_start_consumer.
// A driver applies one cycle of inputs at a time and pushes the outputs the
// reference model predicts for that cycle into a queue; a monitor pops and
// compares every cycle at the falling edge. Directed scenarios are followed
// by a randomized run. The start FIFO is modelled as a token count.
module tb_kernel_pr_start_consumer;

    localparam int MAX_INFL = 4;

    typedef struct {
        bit          ap_start;
        bit          start_read;
        bit          drain_done;
        bit          err_done;
        int          infl;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start_empty_n;
    logic        start_read;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        drain_req;
    logic        drain_done;
    logic [3:0]  inflight;
    logic [31:0] done_count;
    logic        err_done;

    int          err_cnt;
    int          chk_cnt;
    int          fifo_cnt;
    exp_t        exp_q[$];

    // Reference model: busy means a start request is outstanding.
    bit          m_busy;
    bit          m_err;
    bit          m_dd;
    int          m_infl;
    logic [31:0] m_cnt;

    kernel_pr_start_consumer #(
        .MAX_INFLIGHT(MAX_INFL),
        .INFL_WIDTH  (4),
        .CNT_WIDTH   (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_empty_n(start_empty_n),
        .start_read   (start_read),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .inflight     (inflight),
        .done_count   (done_count),
        .err_done     (err_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison helper shared by the monitor and directed checks.
    task automatic checkOutput(input string name, input longint act, input longint expv);
        chk_cnt++;
        if (act != expv) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic modelReset();
        m_busy = 0;
        m_err  = 0;
        m_dd   = 0;
        m_infl = 0;
        m_cnt  = '0;
    endtask

    // One clock cycle of stimulus: queue the predicted outputs, then advance
    // the model by the handshake rules.
    task automatic applyStimulus(input int add_tokens, input bit rdy, input bit dn, input bit drn);
        exp_t e;
        bit   acc;
        bit   fin;
        bit   nbusy;
        @(posedge clk);
        #1;
        fifo_cnt      = fifo_cnt + add_tokens;
        start_empty_n = (fifo_cnt > 0);
        ap_ready      = rdy;
        ap_done       = dn;
        drain_req     = drn;
        e.ap_start    = m_busy;
        e.start_read  = m_busy && rdy;
        e.drain_done  = m_dd;
        e.err_done    = m_err;
        e.infl        = m_infl;
        e.cnt         = m_cnt;
        exp_q.push_back(e);
        acc   = m_busy && rdy;
        fin   = dn && (m_infl > 0);
        if (m_busy) nbusy = !rdy;
        else        nbusy = (fifo_cnt > 0) && !drn && (m_infl < MAX_INFL);
        m_dd   = drn && !m_busy && (m_infl == 0);
        m_err  = m_err || (dn && (m_infl == 0));
        m_infl = m_infl + (acc ? 1 : 0) - (fin ? 1 : 0);
        if (fin) m_cnt = m_cnt + 32'd1;
        m_busy = nbusy;
        #1;
    endtask

    // Finish outstanding work with drain held, then empty the FIFO.
    task automatic settle();
        for (int i = 0; i < 80 && !(m_infl == 0 && !m_busy); i++) begin
            applyStimulus(0, 1, (m_infl > 0), 1);
        end
        checkOutput("settle_reached", (m_infl == 0 && !m_busy), 1);
        fifo_cnt = 0;
        applyStimulus(0, 0, 0, 1);
    endtask

    // FIFO pop on the DUT strobe; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (reset_n && start_read) fifo_cnt = fifo_cnt - 1;
    end

    // Monitor: compare every cycle the driver has predicted.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("ap_start", ap_start, e.ap_start);
            checkOutput("start_read", start_read, e.start_read);
            checkOutput("drain_done", drain_done, e.drain_done);
            checkOutput("err_done", err_done, e.err_done);
            checkOutput("inflight", inflight, e.infl);
            checkOutput("done_count", done_count, e.cnt);
            if (start_read) checkOutput("read_while_empty", start_empty_n, 1);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] c0;
        bit          drn;
        int          add;
        bit          dn;
        err_cnt       = 0;
        chk_cnt       = 0;
        fifo_cnt      = 0;
        start_empty_n = 0;
        ap_ready      = 0;
        ap_done       = 0;
        drain_req     = 0;
        reset_n       = 0;
        modelReset();
        #1;
        checkOutput("reset_ap_start", ap_start, 0);
        checkOutput("reset_inflight", inflight, 0);
        checkOutput("reset_done_count", done_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;

        $display("[TB] single token");
        applyStimulus(1, 0, 0, 0);
        checkOutput("single_ap_start_t", ap_start, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("single_ap_start_t1", ap_start, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("single_start_read", start_read, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("single_inflight_1", inflight, 1);
        checkOutput("single_ap_start_low", ap_start, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("single_inflight_0", inflight, 0);
        checkOutput("single_done_count", done_count, 1);
        checkOutput("single_err", err_done, 0);
        checkOutput("single_fifo_popped", fifo_cnt, 0);

        $display("[TB] inflight cap");
        applyStimulus(6, 1, 0, 0);
        repeat (12) applyStimulus(0, 1, 0, 0);
        checkOutput("cap_inflight", inflight, 4);
        checkOutput("cap_ap_start", ap_start, 0);
        checkOutput("cap_fifo_left", fifo_cnt, 2);
        applyStimulus(0, 1, 1, 0);
        checkOutput("cap_done_d", ap_start, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("cap_done_d1", ap_start, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("cap_done_d2", ap_start, 1);
        settle();

        $display("[TB] simultaneous accept and done");
        applyStimulus(3, 1, 0, 0);
        for (int i = 0; i < 20 && m_infl < 2; i++) applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 20 && !m_busy; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("simul_setup", (m_infl == 2 && m_busy), 1);
        c0 = m_cnt;
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("simul_inflight", inflight, 2);
        checkOutput("simul_done_count", done_count, c0 + 32'd1);
        settle();

        $display("[TB] spurious done");
        c0 = m_cnt;
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("spur_err", err_done, 1);
        checkOutput("spur_done_count", done_count, c0);
        applyStimulus(1, 1, 0, 0);
        repeat (4) applyStimulus(0, 1, 0, 0);
        checkOutput("spur_err_sticky", err_done, 1);
        checkOutput("spur_start_ok", inflight, 1);
        settle();

        $display("[TB] drain");
        applyStimulus(3, 0, 0, 0);
        for (int i = 0; i < 20 && !m_busy; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain_hold_start", ap_start, 1);
        applyStimulus(0, 1, 0, 1);
        repeat (5) applyStimulus(0, 1, 0, 1);
        checkOutput("drain_no_more_reads", fifo_cnt, 2);
        checkOutput("drain_inflight", inflight, 1);
        checkOutput("drain_done_busy", drain_done, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain_done_d1", drain_done, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("drain_done_d2", drain_done, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("drain_done_held", drain_done, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("drain_done_fall", drain_done, 0);
        settle();

        $display("[TB] async reset mid-issue");
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 20 && !m_busy; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_pre_ap_start", ap_start, 1);
        @(negedge clk);
        #2;
        reset_n = 0;
        #1;
        checkOutput("rst_ap_start", ap_start, 0);
        checkOutput("rst_start_read", start_read, 0);
        checkOutput("rst_inflight", inflight, 0);
        checkOutput("rst_done_count", done_count, 0);
        checkOutput("rst_err", err_done, 0);
        checkOutput("rst_drain_done", drain_done, 0);
        start_empty_n = 0;
        ap_ready      = 0;
        ap_done       = 0;
        drain_req     = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        modelReset();
        checkOutput("rst_token_kept", fifo_cnt, 1);

        $display("[TB] random run");
        drn = 0;
        for (int i = 0; i < 600; i++) begin
            add = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if ($urandom_range(0, 24) == 0) drn = ~drn;
            if (m_infl > 0) dn = ($urandom_range(0, 2) == 0);
            else            dn = ($urandom_range(0, 39) == 0);
            applyStimulus(add, bit'($urandom_range(0, 1)), dn, drn);
        end
        settle();

        repeat (2) @(posedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_kernel_pr_start_consumer
